fifo_write_arbiter: RTL



---
 rtl/fifo_pkg.sv | 14 +
 rtl/fifo_write_arbiter_if.sv | 31 +++
 rtl/fifo_write_arbiter_rr_arbiter.sv | 36 +++
 rtl/fifo_write_arbiter.sv | 79 +++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO write side: default widths and
// pointer Gray-code conversion.
package fifo_pkg;

  localparam int DATA_SIZE_DEF = 8;
  localparam int ADDR_SIZE_DEF = 3;
  localparam int NUM_REQ_DEF   = 3;

  // Callers truncate the result to their pointer width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Write-side bundle between the requesters/read domain (master) and the
// write arbiter (slave).
interface fifo_write_arbiter_if
  import fifo_pkg::*;
#(
  parameter int data_size = DATA_SIZE_DEF,
  parameter int addr_size = ADDR_SIZE_DEF,
  parameter int num_req   = NUM_REQ_DEF
) ();

  logic [num_req-1:0]           req;
  logic [num_req*data_size-1:0] req_data;
  logic [addr_size:0]           read_ptr_gray;
  logic [num_req-1:0]           grant;
  logic                         write_en;
  logic [data_size-1:0]         write_data;
  logic [addr_size-1:0]         write_ptr_binary;
  logic [addr_size:0]           write_ptr_gray;
  logic                         fifo_full;

  modport master (
    output req, req_data, read_ptr_gray,
    input  grant, write_en, write_data, write_ptr_binary, write_ptr_gray, fifo_full
  );

  modport slave (
    input  req, req_data, read_ptr_gray,
    output grant, write_en, write_data, write_ptr_binary, write_ptr_gray, fifo_full
  );

endinterface

// File: rtl/fifo_write_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: searches from last_grant+1 (mod num_req)
// and grants the first asserted request when enabled.
module rr_arbiter #(
  parameter int num_req = 3
) (
  input  logic [num_req-1:0]         req,
  input  logic [$clog2(num_req)-1:0] last_grant,
  input  logic                       enable,
  output logic [num_req-1:0]         grant,
  output logic [$clog2(num_req)-1:0] grant_idx
);

  localparam int          IDX_W = $clog2(num_req);
  localparam int unsigned NUM_U = num_req;

  logic [IDX_W-1:0] w_cand;
  logic             w_found;

  always_comb begin
    grant     = '0;
    grant_idx = last_grant;
    w_cand    = '0;
    w_found   = 1'b0;
    if (enable) begin
      for (int unsigned off = 1; off <= NUM_U; off++) begin
        w_cand = IDX_W'((32'(last_grant) + off) % NUM_U);
        if (!w_found && req[w_cand]) begin
          w_found       = 1'b1;
          grant[w_cand] = 1'b1;
          grant_idx     = w_cand;
        end
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Write-domain controller of the dual-clock FIFO: round-robin access to the
// array write port, write pointers, read-pointer synchroniser and full flag.
module fifo_write_arbiter
  import fifo_pkg::*;
#(
  parameter int data_size = DATA_SIZE_DEF,
  parameter int addr_size = ADDR_SIZE_DEF,
  parameter int num_req   = NUM_REQ_DEF
) (
  input  logic                 write_clk,
  input  logic                 write_rst_n,
  fifo_write_arbiter_if.slave  bus
);

  localparam int PW    = addr_size + 1;
  localparam int IDX_W = $clog2(num_req);

  logic [PW-1:0]      r_bin, r_gray, r_rq1, r_rq2;
  logic               r_full;
  logic [IDX_W-1:0]   r_last_grant;

  logic [num_req-1:0] w_grant;
  logic [IDX_W-1:0]   w_grant_idx;
  logic               w_arb_en;
  logic               w_write_en;
  logic [PW-1:0]      w_bin_next, w_gray_next, w_full_match;
  logic [data_size-1:0] w_write_data;

  // Gating with reset makes grant drop asynchronously while reset is held.
  assign w_arb_en = write_rst_n & ~r_full;

  rr_arbiter #(.num_req(num_req)) u_rr_arbiter (
    .req        (bus.req),
    .last_grant (r_last_grant),
    .enable     (w_arb_en),
    .grant      (w_grant),
    .grant_idx  (w_grant_idx)
  );

  assign w_write_en   = |w_grant;
  assign w_bin_next   = r_bin + PW'(w_write_en);
  assign w_gray_next  = PW'(bin2gray(32'(w_bin_next)));
  assign w_full_match = {~r_rq2[addr_size:addr_size-1], r_rq2[addr_size-2:0]};

  always_comb begin
    w_write_data = '0;
    for (int unsigned k = 0; k < num_req; k++) begin
      if (w_grant[k]) w_write_data = bus.req_data[k*data_size +: data_size];
    end
  end

  always_ff @(posedge write_clk or negedge write_rst_n) begin
    if (!write_rst_n) begin
      r_bin        <= '0;
      r_gray       <= '0;
      r_rq1        <= '0;
      r_rq2        <= '0;
      r_full       <= 1'b0;
      r_last_grant <= IDX_W'(num_req - 1);
    end else begin
      r_rq1  <= bus.read_ptr_gray;
      r_rq2  <= r_rq1;
      r_full <= (w_gray_next == w_full_match);
      if (w_write_en) begin
        r_bin        <= w_bin_next;
        r_gray       <= w_gray_next;
        r_last_grant <= w_grant_idx;
      end
    end
  end

  assign bus.grant            = w_grant;
  assign bus.write_en         = w_write_en;
  assign bus.write_data       = w_write_data;
  assign bus.write_ptr_binary = r_bin[addr_size-1:0];
  assign bus.write_ptr_gray   = r_gray;
  assign bus.fifo_full        = r_full;

endmodule
